decoder_pipe: RTL and testbench
===============================

Name: decoder_pipe

Overview:
- Parametrised, pipelined N-to-2^N decoder with valid/ready handshakes on input and output.
- Successor to the fixed-size combinational decoder tree.
- Adds per-transaction output modes (one-hot, thermometer, active-low one-hot), a two-stage predecode/combine pipeline for wide outputs, and backpressure.
- Sits between address/select generators and register-file or memory word-line enables.

Parameters:
IN_W, 5, input index width; output width OUT_W = 2**IN_W (localparam); legal range 2..8.
LO_W, IN_W/2, index bits predecoded in the low group; high group width HI_W = IN_W-LO_W; legal range 1..IN_W-1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  request present
in_ready  output  1  stage 1 can accept this cycle
enable  input  1  per-request decoder enable; 0 gives an inactive output word
IN  input  IN_W  index to decode
mode  input  2  0 one-hot, 1 thermometer, 2 active-low one-hot, 3 reserved (treated as 0)
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
OUT  output  OUT_W  decoded word
out_idx  output  IN_W  index that produced OUT
err_mode  output  1  sticky flag, set when mode 3 is accepted

Behaviour:
- Single clock domain. reset is asynchronous and active-high.
- Reset values while reset is high: s1_valid=0, out_valid=0, OUT=0, out_idx=0, err_mode=0, all internal predecode registers 0.
- Reset asserted mid-transfer discards every in-flight request. No output is produced for it after reset releases.
- Stage 1 (predecode), registered on an input handshake (in_valid & in_ready):
  - hi_oh = 2^HI_W one-hot of IN[IN_W-1:LO_W], gated by enable.
  - lo_oh = 2^LO_W one-hot of IN[LO_W-1:0].
  - For thermometer mode, hi_th and lo_th are also captured: bit k set iff k <= field value.
  - Stage 1 also captures mode, enable and IN.
- Stage 2 (combine) produces OUT[h*2^LO_W + l]:
  - mode 0: hi_oh[h] & lo_oh[l].
  - mode 1: enable & (h < hi or (h == hi and l <= lo)). Bits 0..IN are set; IN=OUT_W-1 gives all ones.
  - mode 2: bitwise inverse of the mode-0 result. enable=0 gives all ones.
  - enable=0 in modes 0 and 1 gives all zeros.
  - mode 3 is decoded as mode 0 and sets err_mode when accepted into stage 1. err_mode clears only on reset.
- Latency: 2 cycles from an input handshake to out_valid, when not stalled.
- Throughput: 1 request per cycle when out_ready is held high.
- Handshake:
  - Stage 2 loads when s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | (!out_valid | out_ready). in_ready is combinational from out_ready; there is no path from in_valid to in_ready.
  - out_valid stays high and OUT/out_idx stay stable until out_ready is seen.
  - in_valid must not depend on in_ready. Data presented with in_valid=0 is ignored.
- Simultaneous events:
  - Output accept and new stage-1 load in the same cycle: both happen, and the pipeline advances without a bubble.
  - Full pipeline (s1_valid=1, out_valid=1) with out_ready=0: in_ready=0 and nothing moves.
- When out_valid=0, OUT holds its last value. The consumer qualifies OUT with out_valid.
- No combinational path from IN to OUT.

Test Plan:
1. Reset, then accept IN=5'd19, enable=1, mode=0, out_ready=1 -> out_valid asserted 2 cycles later with OUT=32'h0008_0000 and out_idx=19.
2. Accept IN=5'd4, mode=1, then IN=5'd31, mode=1 back-to-back -> OUT=32'h0000_001F, then OUT=32'hFFFF_FFFF on consecutive cycles.
3. Accept IN=5'd0 with enable=0 in mode 0, then in mode 2 -> OUT=32'h0, then OUT=32'hFFFF_FFFF. out_valid is still asserted for both.
4. Hold out_ready=0, stream 4 requests -> 2 accepted, then in_ready=0 and OUT stable. Release out_ready -> all 4 results emerge in order, none lost or duplicated.
5. Accept IN=5'd2 with mode=3 -> OUT=32'h0000_0004 and err_mode=1, which stays high across later good requests.
6. Assert reset asynchronously (mid-cycle) with 2 requests in flight -> out_valid, OUT and err_mode go to 0 immediately, and no output appears after release. Repeat test 1 with IN_W=8, LO_W=3: IN=8'd200 -> only OUT bit 200 set.

Source files
------------

// File: rtl/decoder_pipe.sv
// Two-stage pipelined N-to-2^N decoder: stage 1 predecodes the high and low index
// groups, stage 2 combines them into a one-hot, thermometer or active-low word.
module decoder_pipe #(
  parameter int IN_W = 5,
  parameter int LO_W = IN_W / 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    enable,
  input  logic [IN_W-1:0]         IN,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(1<<IN_W)-1:0]    OUT,
  output logic [IN_W-1:0]         out_idx,
  output logic                    err_mode
);

  localparam int OUT_W = 1 << IN_W;
  localparam int HI_W  = IN_W - LO_W;
  localparam int HN    = 1 << HI_W;
  localparam int LN    = 1 << LO_W;

  localparam logic [1:0] MODE_OH   = 2'd0;
  localparam logic [1:0] MODE_TH   = 2'd1;
  localparam logic [1:0] MODE_OHN  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; a producer holds valid and its data stable until that edge.

  logic           s1_valid_q;
  logic [HN-1:0]  hi_oh_q, hi_oh_d;
  logic [LN-1:0]  lo_oh_q, lo_oh_d;
  logic [HN-1:0]  hi_th_q, hi_th_d;
  logic [LN-1:0]  lo_th_q, lo_th_d;
  logic [1:0]     mode_q, mode_d;
  logic           en_q;
  logic [IN_W-1:0] idx_q;

  logic             out_valid_q;
  logic [OUT_W-1:0] out_q, out_d;
  logic [IN_W-1:0]  out_idx_q;
  logic             err_mode_q;

  logic [HI_W-1:0] hi_f;
  logic [LO_W-1:0] lo_f;
  logic            in_fire;
  logic            s2_load;
  logic            s2_free;

  assign hi_f    = IN[IN_W-1:LO_W];
  assign lo_f    = IN[LO_W-1:0];
  assign s2_free = !out_valid_q || out_ready;
  assign s2_load = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;

  // Stage 1 predecode
  assign hi_oh_d = enable ? (HN'(1) << hi_f) : '0;
  assign lo_oh_d = LN'(1) << lo_f;
  assign mode_d  = (mode == MODE_RSVD) ? MODE_OH : mode;

  for (genvar k = 0; k < HN; k++) begin : g_hi_th
    assign hi_th_d[k] = (HI_W'(k) <= hi_f);
  end

  for (genvar k = 0; k < LN; k++) begin : g_lo_th
    assign lo_th_d[k] = (LO_W'(k) <= lo_f);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      hi_oh_q    <= '0;
      lo_oh_q    <= '0;
      hi_th_q    <= '0;
      lo_th_q    <= '0;
      mode_q     <= MODE_OH;
      en_q       <= 1'b0;
      idx_q      <= '0;
      err_mode_q <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        hi_oh_q    <= hi_oh_d;
        lo_oh_q    <= lo_oh_d;
        hi_th_q    <= hi_th_d;
        lo_th_q    <= lo_th_d;
        mode_q     <= mode_d;
        en_q       <= enable;
        idx_q      <= IN;
        if (mode == MODE_RSVD) begin
          err_mode_q <= 1'b1;
        end
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // Stage 2 combine: bit h*LN+l pairs high group h with low group l
  logic [OUT_W-1:0] comb_oh;
  logic [OUT_W-1:0] comb_th;

  for (genvar gh = 0; gh < HN; gh++) begin : g_hi
    for (genvar gl = 0; gl < LN; gl++) begin : g_lo
      localparam int B = gh * LN + gl;
      assign comb_oh[B] = hi_oh_q[gh] & lo_oh_q[gl];
      // below the selected high group, or inside it up to the low index
      assign comb_th[B] = en_q & ((hi_th_q[gh] & ~hi_oh_q[gh]) | (hi_oh_q[gh] & lo_th_q[gl]));
    end
  end

  always_comb begin
    out_d = comb_oh;
    unique case (mode_q)
      MODE_TH:  out_d = comb_th;
      MODE_OHN: out_d = ~comb_oh;
      default:  out_d = comb_oh;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_idx_q   <= '0;
    end else begin
      if (s2_load) begin
        out_valid_q <= 1'b1;
        out_q       <= out_d;
        out_idx_q   <= idx_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign OUT       = out_q;
  assign out_idx   = out_idx_q;
  assign err_mode  = err_mode_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: a 5-bit instance for the main scenarios and an
// 8-bit instance (LO_W=3) for wide outputs, each checked by its own scoreboard.
module tb_decoder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        in_valid, enable, out_ready;
  logic [4:0]  in_idx;
  logic [1:0]  mode;
  logic        in_ready, out_valid, err_mode;
  logic [31:0] out_word;
  logic [4:0]  out_idx;

  logic         in_valid_8, enable_8, out_ready_8;
  logic [7:0]   in_idx_8;
  logic [1:0]   mode_8;
  logic         in_ready_8, out_valid_8, err_mode_8;
  logic [255:0] out_word_8;
  logic [7:0]   out_idx_8;

  decoder_pipe #(.IN_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .enable(enable), .IN(in_idx), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .OUT(out_word), .out_idx(out_idx), .err_mode(err_mode)
  );

  decoder_pipe #(.IN_W(8), .LO_W(3)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .enable(enable_8), .IN(in_idx_8), .mode(mode_8), .out_valid(out_valid_8),
    .out_ready(out_ready_8), .OUT(out_word_8), .out_idx(out_idx_8), .err_mode(err_mode_8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [36:0]  exp_q[$];
  logic [263:0] exp8_q[$];
  logic [36:0]  e5;
  logic [263:0] e8;

  task automatic check(input string name, input logic [263:0] act, input logic [263:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitors: a transfer completes on the next rising edge when valid & ready
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out5: got idx %0d word %h, expected no output", out_idx, out_word);
      end else begin
        e5 = exp_q.pop_front();
        check("out5", {227'd0, out_idx, out_word}, {227'd0, e5});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid_8 && out_ready_8) begin
      if (exp8_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out8: got idx %0d word %h, expected no output", out_idx_8, out_word_8);
      end else begin
        e8 = exp8_q.pop_front();
        check("out8", {out_idx_8, out_word_8}, e8);
      end
    end
  end

  task automatic send5(input logic [4:0] idx, input logic en, input logic [1:0] md,
                       input logic [31:0] exp_word);
    int guard;
    logic ok;
    in_valid = 1'b1;
    in_idx   = idx;
    enable   = en;
    mode     = md;
    guard    = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 50);
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send5_timeout: in_ready stayed 0 for idx %0d, expected acceptance", idx);
    end else begin
      exp_q.push_back({idx, exp_word});
    end
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] idx, input logic en, input logic [1:0] md,
                       input logic [255:0] exp_word);
    int guard;
    logic ok;
    in_valid_8 = 1'b1;
    in_idx_8   = idx;
    enable_8   = en;
    mode_8     = md;
    guard      = 0;
    do begin
      @(negedge clk);
      ok = in_ready_8;
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 50);
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send8_timeout: in_ready stayed 0 for idx %0d, expected acceptance", idx);
    end else begin
      exp8_q.push_back({idx, exp_word});
    end
    in_valid_8 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    reset = 1'b1;
    in_valid = 1'b0; enable = 1'b0; in_idx = '0; mode = '0; out_ready = 1'b1;
    in_valid_8 = 1'b0; enable_8 = 1'b0; in_idx_8 = '0; mode_8 = '0; out_ready_8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 264'(out_valid), 264'(0));
    check("rst_out",       264'(out_word), 264'(0));
    check("rst_out_idx",   264'(out_idx), 264'(0));
    check("rst_err_mode",  264'(err_mode), 264'(0));
    check("rst_in_ready",  264'(in_ready), 264'(1));
    check("rst_out8",      264'(out_word_8), 264'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: single one-hot request and its two-cycle latency
    send5(5'd19, 1'b1, 2'd0, 32'h0008_0000);
    check("t1_latency_1", 264'(out_valid), 264'(0));
    @(posedge clk);
    #1;
    check("t1_latency_2", 264'(out_valid), 264'(1));
    check("t1_word", 264'(out_word), 264'(32'h0008_0000));

    // Test 2: thermometer, back-to-back, including both boundaries
    send5(5'd4,  1'b1, 2'd1, 32'h0000_001F);
    send5(5'd31, 1'b1, 2'd1, 32'hFFFF_FFFF);
    send5(5'd0,  1'b1, 2'd1, 32'h0000_0001);

    // Test 3: disabled requests and active-low one-hot
    send5(5'd0, 1'b0, 2'd0, 32'h0000_0000);
    send5(5'd0, 1'b0, 2'd2, 32'hFFFF_FFFF);
    send5(5'd0, 1'b0, 2'd1, 32'h0000_0000);
    send5(5'd3, 1'b1, 2'd2, 32'hFFFF_FFF7);
    repeat (4) @(posedge clk);
    #1;

    // Test 4: backpressure fills both stages, then drains in order
    out_ready = 1'b0;
    send5(5'd1, 1'b1, 2'd0, 32'h0000_0002);
    send5(5'd9, 1'b1, 2'd1, 32'h0000_03FF);
    check("t4_stall_ready", 264'(in_ready), 264'(0));
    check("t4_hold_valid", 264'(out_valid), 264'(1));
    fork
      begin
        send5(5'd16, 1'b1, 2'd0, 32'h0001_0000);
        send5(5'd30, 1'b1, 2'd2, 32'hBFFF_FFFF);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        check("t4_still_stalled", 264'(in_ready), 264'(0));
        check("t4_word_stable", 264'(out_word), 264'(32'h0000_0002));
        check("t4_idx_stable", 264'(out_idx), 264'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check("t4_drained", 264'(exp_q.size()), 264'(0));

    // Test 5: reserved mode decodes as one-hot and sets a sticky flag
    check("t5_err_before", 264'(err_mode), 264'(0));
    send5(5'd2, 1'b1, 2'd3, 32'h0000_0004);
    repeat (3) @(posedge clk);
    #1;
    check("t5_err_set", 264'(err_mode), 264'(1));
    send5(5'd10, 1'b1, 2'd0, 32'h0000_0400);
    repeat (3) @(posedge clk);
    #1;
    check("t5_err_sticky", 264'(err_mode), 264'(1));

    // Test 6: asynchronous reset with two requests in flight
    out_ready = 1'b0;
    send5(5'd6, 1'b1, 2'd0, 32'h0000_0040);
    send5(5'd7, 1'b1, 2'd0, 32'h0000_0080);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t6_rst_valid", 264'(out_valid), 264'(0));
    check("t6_rst_out", 264'(out_word), 264'(0));
    check("t6_rst_err", 264'(err_mode), 264'(0));
    check("t6_rst_ready", 264'(in_ready), 264'(1));
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t6_no_output", 264'(out_valid), 264'(0));
    end

    // Wide instance: IN_W=8, LO_W=3
    send8(8'd200, 1'b1, 2'd0, 256'd1 << 200);
    send8(8'd203, 1'b1, 2'd1, (256'd1 << 204) - 256'd1);
    send8(8'd0,   1'b1, 2'd0, 256'd1);
    send8(8'd255, 1'b1, 2'd1, ~256'd0);
    send8(8'd77,  1'b0, 2'd2, ~256'd0);

    guard = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0) && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("final_q5_empty", 264'(exp_q.size()), 264'(0));
    check("final_q8_empty", 264'(exp8_q.size()), 264'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
